// File: rtl/uart_terminal_ctrl.sv
// Byte-level terminal controller between the uart core FIFO ports and the board UI.
// Received bytes are popped into a shifting display history and optionally echoed back,
// with CR expanded to CR LF. One user byte can be queued for transmission; a second send
// while that byte is still waiting is discarded and flagged.
module uart_terminal_ctrl #(
   parameter int unsigned DBIT  = 8,
   parameter int unsigned NHIST = 4,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned CR_LF = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  echo_en,
   input  logic                  clear,
   input  logic [DBIT-1:0]       user_data,
   input  logic                  user_send,
   input  logic [DBIT-1:0]       rx_data,
   input  logic                  rx_empty,
   output logic                  rd_uart,
   output logic [DBIT-1:0]       tx_data,
   input  logic                  tx_full,
   output logic                  wr_uart,
   output logic [NHIST*DBIT-1:0] hist,
   output logic [NHIST-1:0]      hist_valid,
   output logic [CNT_W-1:0]      rx_count,
   output logic                  user_drop,
   output logic                  busy
);

   localparam int unsigned HistW = NHIST * DBIT;
   localparam logic [DBIT-1:0] ChCr = DBIT'(8'h0D);
   localparam logic [DBIT-1:0] ChLf = DBIT'(8'h0A);

   typedef enum logic [1:0] {
      StIdle,
      StPop,
      StEcho,
      StEchoLf
   } state_e;

   state_e            state_q, state_d;
   logic [DBIT-1:0]   byte_q, byte_d;
   logic [DBIT-1:0]   tx_data_q, tx_data_d;
   logic              user_full_q, user_full_d;
   logic [DBIT-1:0]   user_byte_q, user_byte_d;
   logic              user_sent;
   logic              user_lost;
   logic [HistW-1:0]  hist_q, hist_d;
   logic [NHIST-1:0]  hist_valid_q, hist_valid_d;
   logic [CNT_W-1:0]  rx_count_q, rx_count_d;
   logic              user_drop_q, user_drop_d;

   // Next state, FIFO strobes and TX byte; everything is held off while reset is asserted
   always_comb begin
      state_d   = state_q;
      rd_uart   = 1'b0;
      wr_uart   = 1'b0;
      tx_data_d = tx_data_q;
      user_sent = 1'b0;
      if (reset_n) begin
         unique case (state_q)
            StIdle: begin
               // A user byte, even one arriving this very cycle, wins over RX
               if ((user_full_q || user_send) && !tx_full) begin
                  wr_uart   = 1'b1;
                  user_sent = 1'b1;
                  tx_data_d = user_full_q ? user_byte_q : user_data;
               end else if (!rx_empty) begin
                  state_d = StPop;
               end
            end
            StPop: begin
               // rx_empty cannot normally rise here; guard it so a pop never hits an empty FIFO
               if (!rx_empty) begin
                  rd_uart = 1'b1;
                  state_d = echo_en ? StEcho : StIdle;
               end else begin
                  state_d = StIdle;
               end
            end
            StEcho: begin
               if (!tx_full) begin
                  wr_uart   = 1'b1;
                  tx_data_d = byte_q;
                  state_d   = ((CR_LF != 0) && (byte_q == ChCr)) ? StEchoLf : StIdle;
               end
            end
            StEchoLf: begin
               if (!tx_full) begin
                  wr_uart   = 1'b1;
                  tx_data_d = ChLf;
                  state_d   = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Single-entry user buffer: capture, bypass straight to TX, or drop
   always_comb begin
      user_full_d = user_full_q;
      user_byte_d = user_byte_q;
      user_lost   = 1'b0;
      if (user_sent) begin
         user_full_d = 1'b0;
      end
      if (user_send) begin
         if (user_full_q && !user_sent) begin
            user_lost = 1'b1;
         end else if (user_full_q || !user_sent) begin
            user_full_d = 1'b1;
            user_byte_d = user_data;
         end
         // Empty buffer and sent this cycle: the byte went out directly, nothing to hold
      end
   end

   // Received-byte bookkeeping; clear overrides a simultaneous pop
   always_comb begin
      byte_d       = byte_q;
      hist_d       = hist_q;
      hist_valid_d = hist_valid_q;
      rx_count_d   = rx_count_q;
      user_drop_d  = user_drop_q;
      if (rd_uart) begin
         byte_d       = rx_data;
         hist_d       = {hist_q[HistW-DBIT-1:0], rx_data};
         hist_valid_d = {hist_valid_q[NHIST-2:0], 1'b1};
         rx_count_d   = rx_count_q + CNT_W'(1);
      end
      if (user_lost) begin
         user_drop_d = 1'b1;
      end
      if (clear) begin
         hist_d       = '0;
         hist_valid_d = '0;
         rx_count_d   = '0;
         user_drop_d  = 1'b0;
      end
   end

   // FSM, echo byte and TX data registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         byte_q    <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         tx_data_q <= tx_data_d;
      end
   end

   // User buffer registers; a pending byte is discarded by reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         user_full_q <= 1'b0;
         user_byte_q <= '0;
      end else begin
         user_full_q <= user_full_d;
         user_byte_q <= user_byte_d;
      end
   end

   // History, counter and sticky drop flag registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hist_q       <= '0;
         hist_valid_q <= '0;
         rx_count_q   <= '0;
         user_drop_q  <= 1'b0;
      end else begin
         hist_q       <= hist_d;
         hist_valid_q <= hist_valid_d;
         rx_count_q   <= rx_count_d;
         user_drop_q  <= user_drop_d;
      end
   end

   // tx_data follows the byte being pushed this cycle, otherwise holds the last one
   assign tx_data    = tx_data_d;
   assign hist       = hist_q;
   assign hist_valid = hist_valid_q;
   assign rx_count   = rx_count_q;
   assign user_drop  = user_drop_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_terminal_ctrl.sv
// Directed bench for uart_terminal_ctrl: a per-cycle vector table plus hand-written
// sequences for clear-during-pop and counter wrap (the latter on a 4-bit counter instance).
module tb_uart_terminal_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        echo_en;
   logic        clear;
   logic [7:0]  user_data;
   logic        user_send;
   logic [7:0]  rx_data;
   logic        rx_empty;
   logic        tx_full;
   logic        rd_uart, wr_uart, user_drop, busy;
   logic [7:0]  tx_data;
   logic [31:0] hist;
   logic [3:0]  hist_valid;
   logic [15:0] rx_count;

   logic        s_rd_uart, s_wr_uart, s_user_drop, s_busy;
   logic [7:0]  s_tx_data;
   logic [31:0] s_hist;
   logic [3:0]  s_hist_valid;
   logic [3:0]  s_rx_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_terminal_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .echo_en    (echo_en),
      .clear      (clear),
      .user_data  (user_data),
      .user_send  (user_send),
      .rx_data    (rx_data),
      .rx_empty   (rx_empty),
      .rd_uart    (rd_uart),
      .tx_data    (tx_data),
      .tx_full    (tx_full),
      .wr_uart    (wr_uart),
      .hist       (hist),
      .hist_valid (hist_valid),
      .rx_count   (rx_count),
      .user_drop  (user_drop),
      .busy       (busy)
   );

   // Same stimulus, narrow counter so the wrap is reachable in a few dozen cycles
   uart_terminal_ctrl #(.CNT_W(4)) dut_w4 (
      .clk        (clk),
      .reset_n    (reset_n),
      .echo_en    (echo_en),
      .clear      (clear),
      .user_data  (user_data),
      .user_send  (user_send),
      .rx_data    (rx_data),
      .rx_empty   (rx_empty),
      .rd_uart    (s_rd_uart),
      .tx_data    (s_tx_data),
      .tx_full    (tx_full),
      .wr_uart    (s_wr_uart),
      .hist       (s_hist),
      .hist_valid (s_hist_valid),
      .rx_count   (s_rx_count),
      .user_drop  (s_user_drop),
      .busy       (s_busy)
   );

   typedef struct {
      logic        rn, ec, cl, us;
      logic [7:0]  ud;
      logic        re;
      logic [7:0]  rxd;
      logic        tf;
      logic        rd, wr;
      logic [7:0]  txd;
      logic        bsy;
      logic        chk;
      logic [31:0] hst;
      logic [3:0]  hv;
      logic [15:0] cnt;
      logic        drp;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(bit rn, bit ec, bit cl, bit us, logic [7:0] ud, bit re,
                              logic [7:0] rxd, bit tf, bit rd, bit wr, logic [7:0] txd,
                              bit bsy);
      vec_t t;
      t.rn = rn; t.ec = ec; t.cl = cl; t.us = us; t.ud = ud; t.re = re; t.rxd = rxd;
      t.tf = tf; t.rd = rd; t.wr = wr; t.txd = txd; t.bsy = bsy;
      t.chk = 1'b0; t.hst = '0; t.hv = '0; t.cnt = '0; t.drp = 1'b0;
      return t;
   endfunction

   // Attach expected register state (as seen during the last vector) to the last vector
   task automatic st(input logic [31:0] h, input logic [3:0] hv, input logic [15:0] c,
                     input logic d);
      int k;
      k = tbl.size() - 1;
      tbl[k].chk = 1'b1;
      tbl[k].hst = h;
      tbl[k].hv  = hv;
      tbl[k].cnt = c;
      tbl[k].drp = d;
   endtask

   // Two-cycle pop of one byte from an otherwise empty RX FIFO, starting from idle
   task automatic pop_byte(input logic [7:0] b, input bit clr_in_pop);
      @(posedge clk); #1;
      rx_empty = 1'b0; rx_data = b; user_send = 1'b0; clear = 1'b0;
      #4 check("idle_rd", {31'd0, rd_uart}, 32'd0);
      @(posedge clk); #1;
      clear = clr_in_pop;
      #4 check("pop_rd", {31'd0, rd_uart}, 32'd1);
      @(posedge clk); #1;
      rx_empty = 1'b1; clear = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; echo_en = 1'b0; clear = 1'b0; user_data = '0; user_send = 1'b0;
      rx_data = '0; rx_empty = 1'b1; tx_full = 1'b0;

      //           rn ec cl us ud     re rxd    tf   rd wr txd    busy
      // Reset held with RX pending and a user send: nothing moves
      tbl.push_back(v(0, 0, 0, 1, 8'h77, 0, 8'h41, 0, 0, 0, 8'h00, 0));
      tbl.push_back(v(0, 0, 0, 1, 8'h77, 0, 8'h41, 0, 0, 0, 8'h00, 0)); st(0, 0, 0, 0);
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0)); st(0, 0, 0, 0);
      // Echo off, RX 41 42 43
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h41, 0, 0, 0, 8'h00, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h41, 0, 1, 0, 8'h00, 1));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h42, 0, 0, 0, 8'h00, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h42, 0, 1, 0, 8'h00, 1));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h43, 0, 0, 0, 8'h00, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h43, 0, 1, 0, 8'h00, 1));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0));
      st(32'h00414243, 4'b0111, 16'd3, 0);
      // Echo on, RX 0D while TX full for five cycles, then CR LF back to back
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 8'h0D, 1, 0, 0, 8'h00, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 8'h0D, 1, 1, 0, 8'h00, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h0D, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h0A, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h0A, 0));
      st(32'h4142430D, 4'b1111, 16'd4, 0);
      // User 55 in the same cycle RX 31 appears: 55 goes first
      tbl.push_back(v(1, 1, 0, 1, 8'h55, 0, 8'h31, 0, 0, 1, 8'h55, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 8'h31, 0, 0, 0, 8'h55, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 8'h31, 0, 1, 0, 8'h55, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h31, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h31, 0));
      st(32'h42430D31, 4'b1111, 16'd5, 0);
      // TX full: AA queued, BB dropped, then only AA goes out
      tbl.push_back(v(1, 1, 0, 1, 8'hAA, 1, 8'h00, 1, 0, 0, 8'h31, 0));
      tbl.push_back(v(1, 1, 0, 1, 8'hBB, 1, 8'h00, 1, 0, 0, 8'h31, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'h31, 0));
      st(32'h42430D31, 4'b1111, 16'd5, 1);
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'hAA, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'hAA, 0));
      st(32'h42430D31, 4'b1111, 16'd5, 1);
      // User byte queued during a pop waits until the CR LF echo completes
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 0, 8'h0D, 0, 0, 0, 8'hAA, 0));
      tbl.push_back(v(1, 1, 0, 1, 8'h66, 0, 8'h0D, 0, 1, 0, 8'hAA, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h0D, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h0A, 1));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h66, 0));
      tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h66, 0));
      st(32'h430D310D, 4'b1111, 16'd6, 1);
      // Clear pulse from idle
      tbl.push_back(v(1, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h66, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h66, 0));
      st(32'h0, 4'b0000, 16'd0, 0);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         reset_n = tbl[i].rn; echo_en = tbl[i].ec; clear = tbl[i].cl;
         user_send = tbl[i].us; user_data = tbl[i].ud; rx_empty = tbl[i].re;
         rx_data = tbl[i].rxd; tx_full = tbl[i].tf;
         #4;
         check($sformatf("v%0d rd_wr_busy", i), {29'd0, rd_uart, wr_uart, busy},
               {29'd0, tbl[i].rd, tbl[i].wr, tbl[i].bsy});
         check($sformatf("v%0d tx_data", i), {24'd0, tx_data}, {24'd0, tbl[i].txd});
         if (tbl[i].chk) begin
            check($sformatf("v%0d hist", i), hist, tbl[i].hst);
            check($sformatf("v%0d hist_valid", i), {28'd0, hist_valid}, {28'd0, tbl[i].hv});
            check($sformatf("v%0d rx_count", i), {16'd0, rx_count}, {16'd0, tbl[i].cnt});
            check($sformatf("v%0d user_drop", i), {31'd0, user_drop}, {31'd0, tbl[i].drp});
         end
      end

      // Clear in the pop cycle: clear wins, the byte is still echoed
      pop_byte(8'h11, 1'b0);
      pop_byte(8'h22, 1'b0);
      #4 check("count_before_clear", {16'd0, rx_count}, 32'd2);
      echo_en = 1'b1;
      pop_byte(8'h5A, 1'b1);
      #4;
      check("clr_pop_wr", {31'd0, wr_uart}, 32'd1);
      check("clr_pop_txd", {24'd0, tx_data}, 32'h5A);
      check("clr_pop_count", {16'd0, rx_count}, 32'd0);
      check("clr_pop_hist", hist, 32'd0);
      check("clr_pop_hv", {28'd0, hist_valid}, 32'd0);
      check("clr_pop_w4_count", {28'd0, s_rx_count}, 32'd0);
      @(posedge clk); #1;
      echo_en = 1'b0;

      // Counter wrap on the 4-bit instance
      for (int i = 1; i <= 15; i++) pop_byte(8'(i), 1'b0);
      #4 check("w4_count_max", {28'd0, s_rx_count}, 32'hF);
      pop_byte(8'h10, 1'b0);
      #4;
      check("w4_count_wrap", {28'd0, s_rx_count}, 32'd0);
      check("count_16", {16'd0, rx_count}, 32'd16);
      check("hist_last4", hist, 32'h0D0E0F10);
      check("hv_saturated", {28'd0, hist_valid}, 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
